// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit with redirect and stall hold
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   imem_req/imem_addr : read request and word-aligned byte address to instruction memory
//   imem_ready/rdata   : memory returns the requested word in the cycle ready is high
//   stall              : decoder is not taking the held instruction
//   pc_load/pc_target  : branch/jump redirect (highest priority in every state)
//   instr/instr_valid  : held instruction word (NOP_INSTR when nothing is held)
//   pc                 : address of the word on instr
//   controlOverride    : decoder override, high whenever instr_valid is low
module instr_fetch #(
  parameter int          N         = 32,
  parameter logic [N-1:0] RESET_PC  = '0,
  parameter logic [31:0]  NOP_INSTR = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  input  logic         stall,
  input  logic         pc_load,
  input  logic [N-1:0] pc_target,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic [N-1:0] pc,
  output logic         controlOverride
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [N-1:0] PC_STEP = N'(4);

  state_t       state, state_n;
  logic [N-1:0] fetch_pc, fetch_pc_n, pc_n;
  logic [31:0]  instr_n;
  logic         valid_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      // Request outputs are registered from the next state so they are
      // glitch-free and line up with the cycle the FSM sits in FETCH.
      imem_req    <= (state_n == FETCH);
      imem_addr   <= fetch_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    pc_n       = pc;
    instr_n    = instr;
    valid_n    = instr_valid;
    if (pc_load) begin
      // Redirect wins over everything, including a coincident imem_ready,
      // whose data is dropped because it belongs to the old path.
      fetch_pc_n = {pc_target[N-1:2], 2'b00};
      valid_n    = 1'b0;
      instr_n    = NOP_INSTR;
      state_n    = FETCH;
    end else begin
      case (state)
        IDLE: state_n = FETCH;
        FETCH: begin
          if (imem_ready) begin
            instr_n    = imem_rdata;
            pc_n       = fetch_pc;
            valid_n    = 1'b1;
            fetch_pc_n = fetch_pc + PC_STEP;
            state_n    = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_n = 1'b0;
            instr_n = NOP_INSTR;
            state_n = FETCH;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign controlOverride = !instr_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - table-driven and scoreboard bench for instr_fetch
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        controlOverride;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch #(.N(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .pc_load(pc_load), .pc_target(pc_target),
    .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .controlOverride(controlOverride)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        stall;
    logic        ld;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  vec_t   tbl[$];
  vec_t   exp_q[$];
  fetch_t sb_q[$];

  function automatic vec_t mk(input string nm, input logic r, input logic rdy,
                              input logic [31:0] rdata, input logic st, input logic ld,
                              input logic [31:0] tgt, input logic e_req,
                              input logic [31:0] e_addr, input logic [31:0] e_instr,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.nm = nm; v.rst = r; v.rdy = rdy; v.rdata = rdata; v.stall = st; v.ld = ld;
    v.tgt = tgt; v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
    v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A0000;
  endfunction

  task automatic check_out(input vec_t e);
    n_vec++;
    if (imem_req !== e.e_req || imem_addr !== e.e_addr || instr !== e.e_instr ||
        instr_valid !== e.e_valid || pc !== e.e_pc || controlOverride !== !e.e_valid) begin
      n_err++;
      $display("FAIL %s: got req=%0b addr=%h instr=%h valid=%0b pc=%h ovr=%0b, expected req=%0b addr=%h instr=%h valid=%0b pc=%h ovr=%0b",
               e.nm, imem_req, imem_addr, instr, instr_valid, pc, controlOverride,
               e.e_req, e.e_addr, e.e_instr, e.e_valid, e.e_pc, !e.e_valid);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst; imem_ready = v.rdy; imem_rdata = v.rdata;
    stall = v.stall; pc_load = v.ld; pc_target = v.tgt;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out(exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] exp_fpc;
    logic        valid_prev;
    logic        acc;
    fetch_t      f;

    rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
    stall = 1'b0; pc_load = 1'b0; pc_target = '0;

    // Stimulus table: inputs before an edge, outputs expected just after it.
    tbl.push_back(mk("rel_idle",   0, 1, 32'hDEADBEEF, 0, 0, 0, 1, 32'h0,  NOP,          0, 32'h0));
    tbl.push_back(mk("fetch0",     0, 1, 32'h11111111, 0, 0, 0, 0, 32'h4,  32'h11111111, 1, 32'h0));
    tbl.push_back(mk("consume0",   0, 1, 32'hEEEEEEEE, 0, 0, 0, 1, 32'h4,  NOP,          0, 32'h0));
    tbl.push_back(mk("fetch4",     0, 1, 32'h22222222, 0, 0, 0, 0, 32'h8,  32'h22222222, 1, 32'h4));
    tbl.push_back(mk("consume4",   0, 1, 32'hEEEEEEEE, 0, 0, 0, 1, 32'h8,  NOP,          0, 32'h4));
    tbl.push_back(mk("fetch8",     0, 1, 32'h00500093, 0, 0, 0, 0, 32'hC,  32'h00500093, 1, 32'h8));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("hold_stall", 0, 1, 32'hCCCC0000 + i, 1, 0, 0, 0, 32'hC, 32'h00500093, 1, 32'h8));
    tbl.push_back(mk("release",    0, 0, 32'h0,        0, 0, 0, 1, 32'hC,  NOP,          0, 32'h8));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk("wait_ready", 0, 0, 32'hBADBAD00 + i, i % 2 == 0, 0, 0, 1, 32'hC, NOP, 0, 32'h8));
    tbl.push_back(mk("fetchC",     0, 1, 32'h33333333, 0, 0, 0, 0, 32'h10, 32'h33333333, 1, 32'hC));
    tbl.push_back(mk("consumeC",   0, 0, 32'h0,        0, 0, 0, 1, 32'h10, NOP,          0, 32'hC));
    tbl.push_back(mk("ld_vs_rdy",  0, 1, 32'hBAD0BAD0, 0, 1, 32'h103, 1, 32'h100, NOP,   0, 32'hC));
    tbl.push_back(mk("fetch100",   0, 1, 32'h44444444, 0, 0, 0, 0, 32'h104, 32'h44444444, 1, 32'h100));
    tbl.push_back(mk("ld_in_hold", 0, 0, 32'h0,        1, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFC, NOP, 0, 32'h100));
    tbl.push_back(mk("fetch_top",  0, 1, 32'h55555555, 0, 0, 0, 0, 32'h0,  32'h55555555, 1, 32'hFFFFFFFC));
    tbl.push_back(mk("consume_top",0, 0, 32'h0,        0, 0, 0, 1, 32'h0,  NOP,          0, 32'hFFFFFFFC));
    tbl.push_back(mk("fetch_wrap", 0, 1, 32'h66666666, 0, 0, 0, 0, 32'h4,  32'h66666666, 1, 32'h0));

    // Reset state, checked while rst is still high.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_out(mk("reset", 1, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 0, 32'h0));

    foreach (tbl[i]) step(tbl[i]);

    // Reset asserted between edges while a request is outstanding.
    step(mk("to_fetch", 0, 0, 32'h0, 0, 0, 0, 1, 32'h4, NOP, 0, 32'h0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_out(mk("async_rst", 1, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 0, 32'h0));
    step(mk("rdy_in_rst",   1, 1, 32'hDEAD0000, 0, 0, 0, 0, 32'h0, NOP, 0, 32'h0));
    step(mk("rdy_after_rst",0, 1, 32'hDEAD0001, 0, 0, 0, 1, 32'h0, NOP, 0, 32'h0));
    step(mk("first_fetch",  0, 1, 32'h77777777, 0, 0, 0, 0, 32'h4, 32'h77777777, 1, 32'h0));

    // Randomised traffic against a memory model and a fetch scoreboard.
    exp_fpc    = 32'h4;
    valid_prev = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      imem_ready = 1'($urandom_range(0, 1));
      stall      = ($urandom_range(0, 3) == 0);
      pc_load    = ($urandom_range(0, 15) == 0);
      pc_target  = $urandom;
      imem_rdata = mem_word(exp_fpc);
      if (imem_req) check_val("req_addr", imem_addr, exp_fpc);
      acc = imem_req && imem_ready && !pc_load;
      if (acc) begin
        f.pc = exp_fpc;
        f.instr = mem_word(exp_fpc);
        sb_q.push_back(f);
        exp_fpc = exp_fpc + 32'h4;
      end
      if (pc_load) exp_fpc = {pc_target[31:2], 2'b00};
      @(posedge clk);
      #1;
      if (pc_load) begin
        check_val("ld_clears_valid", {31'h0, instr_valid}, 32'h0);
      end else if (instr_valid && !valid_prev) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got valid pc=%h with no fetch pending", pc);
        end else begin
          f = sb_q.pop_front();
          check_val("sb_pc", pc, f.pc);
          check_val("sb_instr", instr, f.instr);
        end
      end
      valid_prev = instr_valid;
    end
    check_val("sb_drained", sb_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
